// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if
// Bundles the ID-stage instruction/control inputs and the hazard-resolution
// results exchanged between decode and the EX operand muxes.
//   inst_in/inst_valid : ID-stage instruction and its qualifier
//   hold/flush         : pipeline freeze and ID-kill controls
//   rs1/rs2/rd         : decoded register fields
//   fwd_sel1/fwd_sel2  : operand source selects (0 = regfile, k+1 = stage k)
//   stall/stall_cnt    : load-use / RAW stall and its saturating counter
// Modports: master drives the instruction side, slave is the scoreboard.
interface hazard_scoreboard_if #(
    parameter int NUM_STAGES = 3,
    parameter int CNT_W      = 16
);
    localparam int SW = $clog2(NUM_STAGES + 1);

    logic [31:0]      inst_in;
    logic             inst_valid;
    logic             hold;
    logic             flush;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [SW-1:0]    fwd_sel1;
    logic [SW-1:0]    fwd_sel2;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output inst_in, inst_valid, hold, flush,
        input  rs1, rs2, rd, fwd_sel1, fwd_sel2, stall, stall_cnt
    );

    modport slave (
        input  inst_in, inst_valid, hold, flush,
        output rs1, rs2, rd, fwd_sel1, fwd_sel2, stall, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// RAW-hazard scoreboard for an RV32I pipeline. Decodes the ID instruction,
// tracks the destinations of NUM_STAGES in-flight instructions after ID and
// produces per-operand forwarding selects, a load-use stall and a saturating
// count of stalled cycles.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : hazard_scoreboard_if.slave (instruction in, decode/hazard out)
module hazard_scoreboard #(
    parameter int NUM_STAGES = 3,
    parameter int LOAD_READY = 1,
    parameter int FWD_EN     = 1,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_scoreboard_if.slave  bus
);
    localparam int SW = $clog2(NUM_STAGES + 1);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    // Tracker: one entry per downstream stage, index 0 = youngest (EX).
    logic [NUM_STAGES-1:0]      v_r;
    logic [NUM_STAGES-1:0][4:0] rd_r;
    logic [NUM_STAGES-1:0]      ld_r;
    logic [CNT_W-1:0]           stall_cnt_r;

    logic [6:0]    opcode_s;
    logic [4:0]    rd_s;
    logic [4:0]    rs1_s;
    logic [4:0]    rs2_s;
    logic          is_load_s;
    logic          hit1_s;
    logic          hit2_s;
    logic          lu1_s;
    logic          lu2_s;
    logic [SW-1:0] idx1_s;
    logic [SW-1:0] idx2_s;
    logic          st1_s;
    logic          st2_s;
    logic [SW-1:0] fwd1_s;
    logic [SW-1:0] fwd2_s;
    logic          stall_s;
    logic          enter_s;
    logic          unused_bits_s;

    // funct3/funct7 do not affect hazards; fold them so they are not dangling.
    assign unused_bits_s = ^{bus.inst_in[31:25], bus.inst_in[14:12]};
    assign opcode_s      = bus.inst_in[6:0];

    // Decode register fields according to the opcode's format.
    always_comb begin
        rd_s      = 5'd0;
        rs1_s     = 5'd0;
        rs2_s     = 5'd0;
        is_load_s = 1'b0;
        if (bus.inst_valid) begin
            case (opcode_s)
                OP_LUI, OP_AUIPC, OP_JAL: begin
                    rd_s = bus.inst_in[11:7];
                end
                OP_JALR, OP_IMM: begin
                    rd_s  = bus.inst_in[11:7];
                    rs1_s = bus.inst_in[19:15];
                end
                OP_LOAD: begin
                    rd_s      = bus.inst_in[11:7];
                    rs1_s     = bus.inst_in[19:15];
                    is_load_s = 1'b1;
                end
                OP_BRANCH, OP_STORE: begin
                    rs1_s = bus.inst_in[19:15];
                    rs2_s = bus.inst_in[24:20];
                end
                OP_OP: begin
                    rd_s  = bus.inst_in[11:7];
                    rs1_s = bus.inst_in[19:15];
                    rs2_s = bus.inst_in[24:20];
                end
                default: begin
                    rd_s      = 5'd0;
                    rs1_s     = 5'd0;
                    rs2_s     = 5'd0;
                    is_load_s = 1'b0;
                end
            endcase
        end else begin
            rd_s      = 5'd0;
            rs1_s     = 5'd0;
            rs2_s     = 5'd0;
            is_load_s = 1'b0;
        end
    end

    // Find the youngest matching stage per operand; the scan stops at the
    // first hit so older producers of the same register are ignored.
    // lu*_s flags a load whose data is not yet available at that stage.
    always_comb begin
        hit1_s = 1'b0;
        hit2_s = 1'b0;
        lu1_s  = 1'b0;
        lu2_s  = 1'b0;
        idx1_s = '0;
        idx2_s = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (!hit1_s && v_r[k] && (rs1_s != 5'd0) && (rd_r[k] == rs1_s)) begin
                hit1_s = 1'b1;
                idx1_s = SW'(k);
                lu1_s  = ld_r[k] && (k < LOAD_READY);
            end else begin
                hit1_s = hit1_s;
            end
            if (!hit2_s && v_r[k] && (rs2_s != 5'd0) && (rd_r[k] == rs2_s)) begin
                hit2_s = 1'b1;
                idx2_s = SW'(k);
                lu2_s  = ld_r[k] && (k < LOAD_READY);
            end else begin
                hit2_s = hit2_s;
            end
        end
    end

    // Resolve each match into either a forward select or a stall request.
    always_comb begin
        st1_s  = 1'b0;
        st2_s  = 1'b0;
        fwd1_s = '0;
        fwd2_s = '0;
        if (FWD_EN != 0) begin
            st1_s  = lu1_s;
            st2_s  = lu2_s;
            fwd1_s = (hit1_s && !lu1_s) ? (idx1_s + SW'(1)) : '0;
            fwd2_s = (hit2_s && !lu2_s) ? (idx2_s + SW'(1)) : '0;
        end else begin
            st1_s  = hit1_s;
            st2_s  = hit2_s;
            fwd1_s = '0;
            fwd2_s = '0;
        end
    end

    // A flushed or bubble ID slot never stalls; flush beats the stall.
    assign stall_s = (st1_s | st2_s) & bus.inst_valid & ~bus.flush;
    // Writes to x0 are tracked as bubbles so they can never match.
    assign enter_s = bus.inst_valid & ~stall_s & ~bus.flush & (rd_s != 5'd0);

    // Advance the tracker one stage per unfrozen cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_r  <= '0;
            rd_r <= '0;
            ld_r <= '0;
        end else if (!bus.hold) begin
            for (int k = 1; k < NUM_STAGES; k++) begin
                v_r[k]  <= v_r[k-1];
                rd_r[k] <= rd_r[k-1];
                ld_r[k] <= ld_r[k-1];
            end
            v_r[0]  <= enter_s;
            rd_r[0] <= rd_s;
            ld_r[0] <= is_load_s;
        end else begin
            v_r  <= v_r;
            rd_r <= rd_r;
            ld_r <= ld_r;
        end
    end

    // Count stalled, unfrozen cycles; saturate at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= '0;
        end else if (stall_s && !bus.hold && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign bus.rs1       = rs1_s;
    assign bus.rs2       = rs2_s;
    assign bus.rd        = rd_s;
    assign bus.fwd_sel1  = fwd1_s;
    assign bus.fwd_sel2  = fwd2_s;
    assign bus.stall     = stall_s;
    assign bus.stall_cnt = stall_cnt_r;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
// Table-driven check of the forwarding configuration plus a hand-written
// sequence on a FWD_EN=0 instance with a 2-bit counter (saturation).
module tb_hazard_scoreboard;
    logic clk;
    logic rst_n;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NUM_STAGES(3), .CNT_W(16)) bus1 ();
    hazard_scoreboard_if #(.NUM_STAGES(3), .CNT_W(2))  bus0 ();

    hazard_scoreboard #(.NUM_STAGES(3), .LOAD_READY(1), .FWD_EN(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
    );

    hazard_scoreboard #(.NUM_STAGES(3), .LOAD_READY(1), .FWD_EN(0), .CNT_W(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
    );

    localparam logic [31:0] ADD5  = 32'h002082B3; // add x5,x1,x2
    localparam logic [31:0] ADD6  = 32'h00128333; // add x6,x5,x1
    localparam logic [31:0] LW5   = 32'h0000A283; // lw x5,0(x1)
    localparam logic [31:0] ADDI5 = 32'h00100293; // addi x5,x0,1
    localparam logic [31:0] ADD55 = 32'h00528333; // add x6,x5,x5
    localparam logic [31:0] ADDI0 = 32'h00100013; // addi x0,x0,1
    localparam logic [31:0] ADD00 = 32'h00000333; // add x6,x0,x0
    localparam logic [31:0] ADD65 = 32'h005303B3; // add x7,x6,x5
    localparam logic [31:0] ADD60 = 32'h000303B3; // add x7,x6,x0

    typedef struct {
        logic        rst_v;
        logic [31:0] inst;
        logic        valid;
        logic        hold;
        logic        flush;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [1:0]  f1;
        logic [1:0]  f2;
        logic        st;
        logic [15:0] cnt;
    } vec_t;

    vec_t tv[$];
    int   n_vec;
    int   n_err;

    task automatic add(input logic r, input logic [31:0] i, input logic v, input logic h,
                       input logic f, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic [1:0] x, input logic [1:0] y,
                       input logic s, input logic [15:0] c);
        vec_t t;
        t.rst_v = r; t.inst = i; t.valid = v; t.hold = h; t.flush = f;
        t.rs1 = a; t.rs2 = b; t.rd = d; t.f1 = x; t.f2 = y; t.st = s; t.cnt = c;
        tv.push_back(t);
    endtask

    task automatic bub(input logic [15:0] c);
        add(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 1'b0, c);
    endtask

    task automatic step0(input string nm, input logic [31:0] i, input logic [1:0] ef1,
                         input logic [1:0] ef2, input logic es, input logic [1:0] ec);
        @(negedge clk);
        bus0.inst_in    = i;
        bus0.inst_valid = 1'b1;
        bus0.hold       = 1'b0;
        bus0.flush      = 1'b0;
        #1;
        n_vec++;
        if (bus0.fwd_sel1 !== ef1 || bus0.fwd_sel2 !== ef2 || bus0.stall !== es ||
            bus0.stall_cnt !== ec) begin
            n_err++;
            $display("FAIL %s: got fwd1=%0d fwd2=%0d stall=%0d cnt=%0d, want fwd1=%0d fwd2=%0d stall=%0d cnt=%0d",
                     nm, bus0.fwd_sel1, bus0.fwd_sel2, bus0.stall, bus0.stall_cnt,
                     ef1, ef2, es, ec);
        end
    endtask

    initial begin
        logic [35:0] got;
        logic [35:0] exp;
        clk   = 1'b0;
        rst_n = 1'b0;
        n_vec = 0;
        n_err = 0;
        bus1.inst_in = 32'h0; bus1.inst_valid = 1'b0; bus1.hold = 1'b0; bus1.flush = 1'b0;
        bus0.inst_in = 32'h0; bus0.inst_valid = 1'b0; bus0.hold = 1'b0; bus0.flush = 1'b0;

        // reset: decode still live, hazard outputs quiet
        add(1'b0, ADD6, 1'b1, 1'b0, 1'b0, 5'd5, 5'd1, 5'd6, 2'd0, 2'd0, 1'b0, 16'd0);
        add(1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 16'd0);
        // ALU -> ALU forward from EX
        add(1'b1, ADD5, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd5, 2'd0, 2'd0, 1'b0, 16'd0);
        add(1'b1, ADD6, 1'b1, 1'b0, 1'b0, 5'd5, 5'd1, 5'd6, 2'd1, 2'd0, 1'b0, 16'd0);
        bub(16'd0); bub(16'd0); bub(16'd0);
        // load-use: one stall, then forward from stage 1
        add(1'b1, LW5,  1'b1, 1'b0, 1'b0, 5'd1, 5'd0, 5'd5, 2'd0, 2'd0, 1'b0, 16'd0);
        add(1'b1, ADD6, 1'b1, 1'b0, 1'b0, 5'd5, 5'd1, 5'd6, 2'd0, 2'd0, 1'b1, 16'd0);
        add(1'b1, ADD6, 1'b1, 1'b0, 1'b0, 5'd5, 5'd1, 5'd6, 2'd2, 2'd0, 1'b0, 16'd1);
        bub(16'd1); bub(16'd1); bub(16'd1);
        // youngest producer wins
        add(1'b1, ADDI5, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5, 2'd0, 2'd0, 1'b0, 16'd1);
        add(1'b1, ADDI5, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5, 2'd0, 2'd0, 1'b0, 16'd1);
        add(1'b1, ADD55, 1'b1, 1'b0, 1'b0, 5'd5, 5'd5, 5'd6, 2'd1, 2'd1, 1'b0, 16'd1);
        bub(16'd1); bub(16'd1); bub(16'd1);
        // x0 writers/readers never forward
        add(1'b1, ADDI0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 16'd1);
        add(1'b1, ADDI0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 16'd1);
        add(1'b1, ADD00, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd6, 2'd0, 2'd0, 1'b0, 16'd1);
        bub(16'd1); bub(16'd1); bub(16'd1);
        // load-use under hold: stall held, counter frozen
        add(1'b1, LW5,  1'b1, 1'b0, 1'b0, 5'd1, 5'd0, 5'd5, 2'd0, 2'd0, 1'b0, 16'd1);
        add(1'b1, ADD6, 1'b1, 1'b1, 1'b0, 5'd5, 5'd1, 5'd6, 2'd0, 2'd0, 1'b1, 16'd1);
        add(1'b1, ADD6, 1'b1, 1'b1, 1'b0, 5'd5, 5'd1, 5'd6, 2'd0, 2'd0, 1'b1, 16'd1);
        add(1'b1, ADD6, 1'b1, 1'b1, 1'b0, 5'd5, 5'd1, 5'd6, 2'd0, 2'd0, 1'b1, 16'd1);
        add(1'b1, ADD6, 1'b1, 1'b0, 1'b0, 5'd5, 5'd1, 5'd6, 2'd0, 2'd0, 1'b1, 16'd1);
        add(1'b1, ADD6, 1'b1, 1'b0, 1'b0, 5'd5, 5'd1, 5'd6, 2'd2, 2'd0, 1'b0, 16'd2);
        bub(16'd2); bub(16'd2); bub(16'd2);
        // flush during load-use: no stall, flushed x6 never enters tracker
        add(1'b1, LW5,  1'b1, 1'b0, 1'b0, 5'd1, 5'd0, 5'd5, 2'd0, 2'd0, 1'b0, 16'd2);
        add(1'b1, ADD6, 1'b1, 1'b0, 1'b1, 5'd5, 5'd1, 5'd6, 2'd0, 2'd0, 1'b0, 16'd2);
        add(1'b1, ADD65, 1'b1, 1'b0, 1'b0, 5'd6, 5'd5, 5'd7, 2'd0, 2'd2, 1'b0, 16'd2);
        bub(16'd2); bub(16'd2); bub(16'd2);
        // reset in the middle of a stall
        add(1'b1, LW5,  1'b1, 1'b0, 1'b0, 5'd1, 5'd0, 5'd5, 2'd0, 2'd0, 1'b0, 16'd2);
        add(1'b1, ADD6, 1'b1, 1'b0, 1'b0, 5'd5, 5'd1, 5'd6, 2'd0, 2'd0, 1'b1, 16'd2);
        add(1'b0, ADD6, 1'b1, 1'b0, 1'b0, 5'd5, 5'd1, 5'd6, 2'd0, 2'd0, 1'b0, 16'd0);
        bub(16'd0);

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            rst_n           = tv[i].rst_v;
            bus1.inst_in    = tv[i].inst;
            bus1.inst_valid = tv[i].valid;
            bus1.hold       = tv[i].hold;
            bus1.flush      = tv[i].flush;
            #1;
            got = {bus1.rs1, bus1.rs2, bus1.rd, bus1.fwd_sel1, bus1.fwd_sel2, bus1.stall, bus1.stall_cnt};
            exp = {tv[i].rs1, tv[i].rs2, tv[i].rd, tv[i].f1, tv[i].f2, tv[i].st, tv[i].cnt};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL vec%0d: got rs1=%0d rs2=%0d rd=%0d fwd1=%0d fwd2=%0d stall=%0d cnt=%0d, want rs1=%0d rs2=%0d rd=%0d fwd1=%0d fwd2=%0d stall=%0d cnt=%0d",
                         i, bus1.rs1, bus1.rs2, bus1.rd, bus1.fwd_sel1, bus1.fwd_sel2,
                         bus1.stall, bus1.stall_cnt, tv[i].rs1, tv[i].rs2, tv[i].rd,
                         tv[i].f1, tv[i].f2, tv[i].st, tv[i].cnt);
            end
        end

        // FWD_EN=0: every RAW match stalls until the producer leaves WB;
        // 2-bit counter reaches 3 and then saturates.
        step0("nofwd_add5",  ADD5,  2'd0, 2'd0, 1'b0, 2'd0);
        step0("nofwd_st0",   ADD6,  2'd0, 2'd0, 1'b1, 2'd0);
        step0("nofwd_st1",   ADD6,  2'd0, 2'd0, 1'b1, 2'd1);
        step0("nofwd_st2",   ADD6,  2'd0, 2'd0, 1'b1, 2'd2);
        step0("nofwd_go",    ADD6,  2'd0, 2'd0, 1'b0, 2'd3);
        step0("sat_st0",     ADD60, 2'd0, 2'd0, 1'b1, 2'd3);
        step0("sat_st1",     ADD60, 2'd0, 2'd0, 1'b1, 2'd3);
        step0("sat_st2",     ADD60, 2'd0, 2'd0, 1'b1, 2'd3);
        step0("sat_go",      ADD60, 2'd0, 2'd0, 1'b0, 2'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
